// File: rtl/oscillator_trigger_sequencer.sv
// Shares one square-wave oscillator voice between prioritised trigger sources and
// shapes it with an attack/hold/release gain envelope before it reaches the mixer.
module oscillator_trigger_sequencer #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter logic [15:0] ATTACK_STEP  = 16'h0100,
  parameter logic [15:0] RELEASE_STEP = 16'h0040,
  parameter logic [15:0] MAX_GAIN     = 16'h4000,
  localparam int unsigned IdW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               osc_rstn,
  input  logic signed [15:0] osc_in,
  output logic signed [15:0] out,
  output logic [IdW-1:0]     active_id,
  output logic               busy
);

  localparam int unsigned HoldW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_SAMPLES - 1);

  typedef enum logic [1:0] {StIdle, StAttack, StHold, StRelease} state_e;

  state_e             state_q, state_d;
  logic [15:0]        gain_q, gain_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [IdW-1:0]     active_id_q, active_id_d;
  logic signed [15:0] out_q, out_d;
  logic               busy_q;

  logic [IdW-1:0]     sel_id;
  logic               any_pending;
  logic               grant;
  logic [NUM_REQ-1:0] grant_oh;

  // Lowest pending index wins; scan from the top so the last hit is the lowest.
  always_comb begin
    sel_id      = '0;
    any_pending = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_id      = IdW'(i);
        any_pending = 1'b1;
      end
    end
  end

  assign grant     = any_pending && ((state_q == StIdle) || (sel_id <= active_id_q));
  assign grant_oh  = grant ? (NUM_REQ'(1) << sel_id) : '0;
  // A request landing on its own grant cycle is absorbed by the grant.
  assign pending_d = (pending_q | req) & ~grant_oh;

  logic [16:0]        attack_sum;
  logic [15:0]        attack_gain;
  logic signed [16:0] release_diff;
  logic [15:0]        release_gain;

  assign attack_sum   = {1'b0, gain_q} + {1'b0, ATTACK_STEP};
  assign attack_gain  = (attack_sum >= {1'b0, MAX_GAIN}) ? MAX_GAIN : attack_sum[15:0];
  assign release_diff = $signed({1'b0, gain_q}) - $signed({1'b0, RELEASE_STEP});
  assign release_gain = release_diff[16] ? 16'h0000 : release_diff[15:0];

  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    hold_cnt_d  = hold_cnt_q;
    active_id_d = active_id_q;
    ack_d       = '0;
    if (grant) begin
      // Gain is left untouched so a preempt restarts the attack without a click.
      state_d     = StAttack;
      hold_cnt_d  = '0;
      active_id_d = sel_id;
      ack_d       = grant_oh;
    end else if (audio_clk_en) begin
      case (state_q)
        StIdle: begin
          gain_d = 16'h0000;
        end
        StAttack: begin
          gain_d = attack_gain;
          if (attack_gain == MAX_GAIN) state_d = StHold;
        end
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            state_d    = StRelease;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        StRelease: begin
          gain_d = release_gain;
          if (release_gain == 16'h0000) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  logic signed [32:0] osc_ext, gain_ext, prod, scaled;

  assign osc_ext  = {{17{osc_in[15]}}, osc_in};
  assign gain_ext = {17'b0, gain_q};
  assign prod     = osc_ext * gain_ext;
  assign scaled   = prod >>> 14;

  always_comb begin
    out_d = out_q;
    if (audio_clk_en) begin
      if (scaled > 33'sd32767) begin
        out_d = 16'sh7fff;
      end else if (scaled < -33'sd32768) begin
        out_d = 16'sh8000;
      end else begin
        out_d = scaled[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state_q     <= StIdle;
      gain_q      <= 16'h0000;
      hold_cnt_q  <= '0;
      pending_q   <= '0;
      ack_q       <= '0;
      active_id_q <= '0;
      out_q       <= 16'sh0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      hold_cnt_q  <= hold_cnt_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      active_id_q <= active_id_d;
      out_q       <= out_d;
      busy_q      <= (state_q != StIdle);
    end
  end

  assign ack       = ack_q;
  assign active_id = active_id_q;
  assign out       = out_q;
  assign busy      = busy_q;
  assign osc_rstn  = busy_q;

endmodule

// File: tb/tb_oscillator_trigger_sequencer.sv
// Bench for oscillator_trigger_sequencer: envelope output checked through a scoreboard of
// expected samples, plus arbitration, preemption, saturation and reset checks.
module tb_oscillator_trigger_sequencer;

  logic               clk = 1'b0;
  logic               I_RSTn = 1'b0;
  logic               audio_clk_en = 1'b0;
  logic [3:0]         req = '0;
  logic [3:0]         ack;
  logic               osc_rstn;
  logic signed [15:0] osc_in = 16'sd10000;
  logic signed [15:0] out;
  logic [1:0]         active_id;
  logic               busy;

  logic [3:0]         req2 = '0;
  logic [3:0]         ack2;
  logic               osc_rstn2;
  logic signed [15:0] osc_in2 = 16'sd32767;
  logic signed [15:0] out2;
  logic [1:0]         active_id2;
  logic               busy2;

  int checks = 0;
  int failures = 0;
  int sb[$];

  int env_full[12] = '{0, 2500, 5000, 7500, 10000, 10000, 10000, 10000, 10000, 7500, 5000, 2500};

  always #5 clk = ~clk;

  oscillator_trigger_sequencer #(
    .NUM_REQ(4), .HOLD_SAMPLES(4), .ATTACK_STEP(16'h1000), .RELEASE_STEP(16'h1000),
    .MAX_GAIN(16'h4000)
  ) u_dut (
    .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en), .req(req), .ack(ack),
    .osc_rstn(osc_rstn), .osc_in(osc_in), .out(out), .active_id(active_id), .busy(busy)
  );

  oscillator_trigger_sequencer #(
    .NUM_REQ(4), .HOLD_SAMPLES(4), .ATTACK_STEP(16'h1000), .RELEASE_STEP(16'h1000),
    .MAX_GAIN(16'h8000)
  ) u_dut_sat (
    .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en), .req(req2), .ack(ack2),
    .osc_rstn(osc_rstn2), .osc_in(osc_in2), .out(out2), .active_id(active_id2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Each strobe's sample appears one clk later; compare against the oldest expectation.
  always @(posedge clk) begin
    if (I_RSTn && audio_clk_en) begin
      #1;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("out", out, sb.pop_front());
    end
  end

  task automatic drive(input logic [3:0] r, input logic en, input int exp);
    @(negedge clk);
    req = r;
    audio_clk_en = en;
    if (en) sb.push_back(exp);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      req = '0;
      audio_clk_en = 1'b0;
    end
  endtask

  task automatic tick(input int exp);
    drive(4'b0000, 1'b1, exp);
    gap(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    gap(3);
    chk("rst_out", out, 0);
    chk("rst_ack", ack, 0);
    chk("rst_osc_rstn", osc_rstn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active_id", active_id, 0);
    @(negedge clk);
    I_RSTn = 1'b1;
    gap(2);

    // 1: single trigger; second req on the grant cycle is absorbed
    drive(4'b0100, 1'b0, 0);
    drive(4'b0100, 1'b0, 0);
    gap(1);
    chk("t1_ack", ack, 4'b0100);
    chk("t1_active_id", active_id, 2);
    gap(1);
    chk("t1_ack_off", ack, 0);
    chk("t1_osc_rstn", osc_rstn, 1);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 12; i++) tick(env_full[i]);
    tick(0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_osc_rstn", osc_rstn, 0);
    gap(4);
    chk("t1_no_replay", busy, 0);
    chk("t1_no_replay_ack", ack, 0);

    // 2: two triggers together, lower index first, other waits for IDLE
    drive(4'b1010, 1'b0, 0);
    gap(2);
    chk("t2_ack1", ack, 4'b0010);
    chk("t2_active1", active_id, 1);
    gap(1);
    for (int i = 0; i < 11; i++) tick(env_full[i]);
    chk("t2_wait_ack", ack, 0);
    chk("t2_wait_active", active_id, 1);
    drive(4'b0000, 1'b1, 2500);
    gap(1);
    chk("t2_ack3_early", ack, 0);
    gap(1);
    chk("t2_ack3", ack, 4'b1000);
    chk("t2_active3", active_id, 3);
    for (int i = 0; i < 12; i++) tick(env_full[i]);
    chk("t2_done", busy, 0);

    // 3: preempt during HOLD, grant coincident with a strobe
    drive(4'b0100, 1'b0, 0);
    gap(2);
    chk("t3_ack2", ack, 4'b0100);
    for (int i = 0; i < 5; i++) tick(env_full[i]);
    drive(4'b0001, 1'b0, 0);
    drive(4'b0000, 1'b1, 10000);
    gap(1);
    chk("t3_ack0", ack, 4'b0001);
    chk("t3_active0", active_id, 0);
    gap(2);
    for (int i = 0; i < 6; i++) tick(10000);
    tick(7500);
    tick(5000);
    tick(2500);
    chk("t3_done", busy, 0);

    // 4: lower-priority trigger during RELEASE waits
    drive(4'b0010, 1'b0, 0);
    gap(2);
    chk("t4_ack1", ack, 4'b0010);
    for (int i = 0; i < 10; i++) tick(env_full[i]);
    drive(4'b1000, 1'b0, 0);
    gap(3);
    chk("t4_no_ack", ack, 0);
    chk("t4_active", active_id, 1);
    tick(5000);
    drive(4'b0000, 1'b1, 2500);
    gap(1);
    chk("t4_ack3_early", ack, 0);
    gap(1);
    chk("t4_ack3", ack, 4'b1000);
    chk("t4_active3", active_id, 3);
    gap(1);

    // 5a: full-scale negative input at unity gain
    for (int i = 0; i < 4; i++) tick(env_full[i]);
    osc_in = -16'sd32768;
    tick(-32768);
    osc_in = 16'sd10000;
    for (int i = 5; i < 12; i++) tick(env_full[i]);
    chk("t5_done", busy, 0);
    chk("t5_sat_idle", out2, 0);

    // 6: reset mid-ATTACK with another source pending
    drive(4'b0001, 1'b0, 0);
    gap(2);
    chk("t6_ack0", ack, 4'b0001);
    tick(0);
    tick(2500);
    drive(4'b0010, 1'b0, 0);
    gap(2);
    chk("t6_pend_no_ack", ack, 0);
    @(negedge clk);
    I_RSTn = 1'b0;
    @(negedge clk);
    I_RSTn = 1'b1;
    chk("t6_out", out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_osc_rstn", osc_rstn, 0);
    chk("t6_active_id", active_id, 0);
    chk("t6_ack", ack, 0);
    gap(4);
    chk("t6_stay_idle", busy, 0);
    chk("t6_no_ack", ack, 0);
    tick(0);

    // 5b: gain above 1.0 saturates positive output
    @(negedge clk);
    req2 = 4'b0001;
    @(negedge clk);
    req2 = 4'b0000;
    gap(1);
    chk("t5b_ack", ack2, 4'b0001);
    for (int k = 1; k <= 9; k++) begin
      tick(0);
      if (k == 3) chk("t5b_mid", out2, 16383);
    end
    chk("t5b_sat", out2, 32767);

    gap(4);
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
